// File: rtl/toast_timer.sv
`default_nettype none
// ============================================================================
// Module      : toast_timer
// Description : Toaster cook-time countdown with a 3-digit BCD setpoint,
//               run/pause/done control and a free-running display scan index.
// Revision    : 1.0 - initial release
// ============================================================================
module toast_timer #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] set_bcd,
    input  logic        load,
    input  logic        start,
    input  logic        cancel,
    output logic [11:0] tLED,
    output logic [1:0]  digit,
    output logic        heater_en,
    output logic        done
);

    localparam int c_PW = $clog2(CLK_HZ);
    localparam int c_SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(CLK_HZ - 1);
    localparam logic [c_SW-1:0] c_SCAN_MAX  = c_SW'(SCAN_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [11:0]     r_tled;
    logic [11:0]     w_tled_nxt;
    logic [11:0]     r_setp;
    logic [11:0]     w_setp_nxt;
    logic [c_PW-1:0] r_presc;
    logic [c_PW-1:0] w_presc_nxt;
    logic [c_SW-1:0] r_scan;
    logic [1:0]      r_digit;
    logic            r_heater;
    logic            r_done;
    logic [11:0]     w_clamped;
    logic [11:0]     w_tled_dec;
    logic            w_tick;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Callers guarantee a nonzero operand, so the hundreds digit never wraps.
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
        h = v[11:8];
        t = v[7:4];
        u = v[3:0];
        if (u != 4'd0) begin
            u = u - 4'd1;
        end else if (t != 4'd0) begin
            u = 4'd9;
            t = t - 4'd1;
        end else begin
            u = 4'd9;
            t = 4'd9;
            h = h - 4'd1;
        end
        return {h, t, u};
    endfunction

    assign w_clamped  = {clamp_digit(set_bcd[11:8]), clamp_digit(set_bcd[7:4]),
                         clamp_digit(set_bcd[3:0])};
    assign w_tled_dec = bcd_dec(r_tled);
    assign w_tick     = (r_presc == c_PRESC_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_tled_nxt  = r_tled;
        w_setp_nxt  = r_setp;
        w_presc_nxt = r_presc;
        if (cancel) begin
            w_state_nxt = S_IDLE;
            w_tled_nxt  = r_setp;
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (r_tled != 12'h000) begin
                            w_state_nxt = S_RUN;
                            w_presc_nxt = '0;
                        end
                    end else if (load) begin
                        w_setp_nxt = w_clamped;
                        w_tled_nxt = w_clamped;
                    end
                end
                S_RUN: begin
                    // The pausing cycle still counts, keeping total RUN time exact.
                    if (w_tick) begin
                        w_presc_nxt = '0;
                        w_tled_nxt  = w_tled_dec;
                    end else begin
                        w_presc_nxt = r_presc + c_PW'(1);
                    end
                    if (w_tick && (w_tled_dec == 12'h000)) begin
                        w_state_nxt = S_DONE;
                    end else if (start) begin
                        w_state_nxt = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        w_state_nxt = S_IDLE;
                        w_tled_nxt  = r_setp;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_tled   <= 12'h000;
            r_setp   <= 12'h000;
            r_presc  <= '0;
            r_heater <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tled   <= w_tled_nxt;
            r_setp   <= w_setp_nxt;
            r_presc  <= w_presc_nxt;
            r_heater <= (w_state_nxt == S_RUN);
            r_done   <= (w_state_nxt == S_DONE) && (r_state != S_DONE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scan  <= '0;
            r_digit <= 2'd0;
        end else if (r_scan == c_SCAN_MAX) begin
            r_scan  <= '0;
            r_digit <= r_digit + 2'd1;
        end else begin
            r_scan  <= r_scan + c_SW'(1);
        end
    end

    assign tLED      = r_tled;
    assign digit     = r_digit;
    assign heater_en = r_heater;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_toast_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_toast_timer
// Description : Scoreboard bench for toast_timer with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_toast_timer;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] set_bcd = 12'h000;
    logic        load    = 1'b0;
    logic        start   = 1'b0;
    logic        cancel  = 1'b0;
    logic [11:0] tLED;
    logic [1:0]  digit;
    logic        heater_en;
    logic        done;

    toast_timer #(
        .CLK_HZ  (4),
        .SCAN_DIV(2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_bcd  (set_bcd),
        .load     (load),
        .start    (start),
        .cancel   (cancel),
        .tLED     (tLED),
        .digit    (digit),
        .heater_en(heater_en),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       nm;
        logic [11:0] tled;
        logic        h;
        logic        d;
        int          dig;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_vec = 0;
    int   n_bad = 0;
    logic drain = 1'b0;

    task automatic push_exp(input int at, input string nm, input logic [11:0] t,
                            input logic h, input logic d, input int dg);
        exp_t e;
        int   i;
        e.cyc  = at;
        e.nm   = nm;
        e.tled = t;
        e.h    = h;
        e.d    = d;
        e.dig  = dg;
        i = 0;
        while (i < q.size() && q[i].cyc <= at) i++;
        q.insert(i, e);
    endtask

    task automatic push_span(input int a, input int b, input string nm,
                             input logic [11:0] t, input logic h, input logic d);
        for (int k = a; k <= b; k++) push_exp(k, nm, t, h, d, -1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic pulse_load(input logic [11:0] v);
        set_bcd = v;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_cancel(input logic with_start);
        cancel = 1'b1;
        start  = with_start;
        tick();
        cancel = 1'b0;
        start  = 1'b0;
    endtask

    // Monitor: compares every expectation whose cycle has arrived.
    always @(negedge clk) begin
        if (drain) begin
            while (q.size() > 0) begin
                m_e = q.pop_front();
                n_vec++;
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d never checked", m_e.nm, m_e.cyc);
            end
        end
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m_e = q.pop_front();
            n_vec++;
            if (m_e.cyc < cyc) begin
                n_bad++;
                $display("FAIL %s: expected at cycle %0d, reached late at %0d", m_e.nm, m_e.cyc, cyc);
            end else if (tLED !== m_e.tled || heater_en !== m_e.h || done !== m_e.d ||
                         (m_e.dig >= 0 && digit !== 2'(m_e.dig))) begin
                n_bad++;
                $display("FAIL %s @%0d: got tLED=%03h heater_en=%b done=%b digit=%0d, required tLED=%03h heater_en=%b done=%b digit=%0d",
                         m_e.nm, cyc, tLED, heater_en, done, digit,
                         m_e.tled, m_e.h, m_e.d, m_e.dig);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int c;
        int a;
        int b;
        int d;
        int e;
        int f;
        int g;

        // Reset, then free-running scan index while idle
        repeat (2) tick();
        r = cyc;
        push_exp(r, "reset", 12'h000, 1'b0, 1'b0, 0);
        for (int k = 0; k <= 16; k++) push_exp(r + k, "scan", 12'h000, 1'b0, 1'b0, (k / 2) % 4);
        reset_n = 1'b1;
        wait_to(r + 17);

        // Basic 3-second countdown and acknowledge
        c = cyc;
        push_exp(c + 1, "load3", 12'h003, 1'b0, 1'b0, -1);
        push_span(c + 2, c + 5, "run3", 12'h003, 1'b1, 1'b0);
        push_span(c + 6, c + 9, "run2", 12'h002, 1'b1, 1'b0);
        push_span(c + 10, c + 13, "run1", 12'h001, 1'b1, 1'b0);
        push_exp(c + 14, "done3", 12'h000, 1'b0, 1'b1, -1);
        push_exp(c + 15, "done_hold", 12'h000, 1'b0, 1'b0, -1);
        push_exp(c + 16, "ack", 12'h003, 1'b0, 1'b0, -1);
        pulse_load(12'h003);
        pulse_start();
        wait_to(c + 15);
        pulse_start();

        // BCD borrow across both digits, then units only
        a = cyc;
        push_exp(a + 5, "b100", 12'h100, 1'b1, 1'b0, -1);
        push_exp(a + 6, "b099", 12'h099, 1'b1, 1'b0, -1);
        push_exp(a + 45, "b090", 12'h090, 1'b1, 1'b0, -1);
        push_exp(a + 46, "b089", 12'h089, 1'b1, 1'b0, -1);
        push_exp(a + 47, "b_cancel", 12'h100, 1'b0, 1'b0, -1);
        pulse_load(12'h100);
        pulse_start();
        wait_to(a + 46);
        pulse_cancel(1'b0);

        // Pause after 6 RUN cycles for 10 cycles, then resume
        b = cyc;
        push_exp(b + 1, "p_load", 12'h002, 1'b0, 1'b0, -1);
        push_span(b + 2, b + 5, "p_run2", 12'h002, 1'b1, 1'b0);
        push_span(b + 6, b + 7, "p_run1", 12'h001, 1'b1, 1'b0);
        push_span(b + 8, b + 17, "p_pause", 12'h001, 1'b0, 1'b0);
        push_span(b + 18, b + 19, "p_resume", 12'h001, 1'b1, 1'b0);
        push_exp(b + 20, "p_done", 12'h000, 1'b0, 1'b1, -1);
        push_exp(b + 21, "p_done_once", 12'h000, 1'b0, 1'b0, -1);
        push_exp(b + 22, "p_ack", 12'h002, 1'b0, 1'b0, -1);
        pulse_load(12'h002);
        pulse_start();
        wait_to(b + 7);
        pulse_start();
        wait_to(b + 17);
        pulse_start();
        wait_to(b + 21);
        pulse_start();

        // Clamp, and load ignored while running
        d = cyc;
        push_exp(d + 1, "clamp", 12'h999, 1'b0, 1'b0, -1);
        push_span(d + 2, d + 4, "load_in_run", 12'h999, 1'b1, 1'b0);
        push_exp(d + 5, "c_cancel", 12'h999, 1'b0, 1'b0, -1);
        pulse_load(12'hABC);
        pulse_start();
        wait_to(d + 3);
        pulse_load(12'h005);
        pulse_cancel(1'b0);

        // Start with zero time stays in IDLE
        e = cyc;
        push_exp(e + 1, "load0", 12'h000, 1'b0, 1'b0, -1);
        push_exp(e + 2, "start0", 12'h000, 1'b0, 1'b0, -1);
        push_exp(e + 3, "start0_hold", 12'h000, 1'b0, 1'b0, -1);
        pulse_load(12'h000);
        pulse_start();
        wait_to(e + 3);

        // Cancel beats start in the same cycle
        f = cyc;
        push_exp(f + 17, "pr006", 12'h006, 1'b1, 1'b0, -1);
        push_exp(f + 18, "pr005", 12'h005, 1'b1, 1'b0, -1);
        push_exp(f + 19, "pr_cancel", 12'h009, 1'b0, 1'b0, -1);
        push_exp(f + 20, "pr_no_done", 12'h009, 1'b0, 1'b0, -1);
        pulse_load(12'h009);
        pulse_start();
        wait_to(f + 18);
        pulse_cancel(1'b1);
        wait_to(f + 21);

        // Asynchronous reset mid-RUN
        g = cyc;
        push_exp(g + 3, "rst_pre", 12'h003, 1'b1, 1'b0, -1);
        pulse_load(12'h003);
        pulse_start();
        wait_to(g + 4);
        push_exp(g + 4, "rst_async", 12'h000, 1'b0, 1'b0, 0);
        push_exp(g + 5, "rst_held", 12'h000, 1'b0, 1'b0, 0);
        push_exp(g + 6, "rst_rel", 12'h000, 1'b0, 1'b0, 0);
        push_exp(g + 7, "rst_scan0", 12'h000, 1'b0, 1'b0, 0);
        push_exp(g + 8, "rst_scan1", 12'h000, 1'b0, 1'b0, 1);
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        wait_to(g + 10);

        drain = 1'b1;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/toast_timer.md
# toast_timer

Cook-time countdown for the toaster. It holds a 3-digit BCD setpoint in seconds and counts it down once per second while the heater runs. It drives the time value and the shared digit-scan index into the 7-segment display stage. The same scan index also selects the temperature digit, and the block signals completion to the heater and buzzer logic.

## Interface
Parameters:
- CLK_HZ, 50_000_000, clock cycles per one-second tick (≥2)
- SCAN_DIV, 50_000, clock cycles per display digit slot (≥1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- set_bcd  in  12  setpoint BCD: [11:8] hundreds, [7:4] tens, [3:0] units
- load  in  1  single-cycle pulse; captures set_bcd
- start  in  1  single-cycle pulse; start / pause / resume / acknowledge
- cancel  in  1  single-cycle pulse; abort to IDLE
- tLED  out  12  remaining time, BCD, same digit order as set_bcd
- digit  out  2  display scan index, 0..3
- heater_en  out  1  high while in RUN
- done  out  1  one-cycle pulse on expiry

## Operation
- Reset values: state IDLE, tLED=000, setpoint register=000, prescaler=0, scan counter=0, digit=0, heater_en=0, done=0.
- Digit clamp: any set_bcd nibble >9 is captured as 9.
- States and transitions:
  - IDLE:
    - load: setpoint ← clamped set_bcd and tLED ← clamped set_bcd on the same edge.
    - start with tLED≠000: go to RUN and clear the prescaler.
    - start with tLED=000: ignored, stay in IDLE.
  - RUN:
    - Prescaler counts 0..CLK_HZ-1. On the edge where it equals CLK_HZ-1, it wraps to 0 and tLED decrements by one BCD second.
    - BCD decrement: units borrow 0→9 from tens; tens borrow 0→9 from hundreds (e.g. 100→099, 010→009).
    - When a decrement yields 000, go to DONE.
    - start: go to PAUSE. The prescaler value is retained.
  - PAUSE:
    - Prescaler and tLED are frozen.
    - start: go back to RUN, continuing from the frozen prescaler value.
  - DONE:
    - tLED=000.
    - start: go to IDLE with tLED ← setpoint, ready for the next toast at the same time.
- Any state: cancel goes to IDLE with tLED ← setpoint and the prescaler cleared.
- Input priority on the same edge: cancel > start > load.
- load is ignored outside IDLE.
- heater_en is registered and equals (next state == RUN). It is high exactly during RUN cycles.
- done is registered and is high for exactly one cycle, the first cycle in DONE. It coincides with tLED first showing 000.
- Scan counter:
  - Free-running, independent of the FSM.
  - Counts 0..SCAN_DIV-1. On the edge where it equals SCAN_DIV-1 it wraps to 0 and digit increments.
  - digit wraps 3→0.
- Arithmetic: tLED never underflows. 000 is reachable only as a terminal value in DONE, or in IDLE after a load of 000.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- load → tLED updated: visible 1 cycle after the pulse edge.
- start in IDLE → heater_en high: 1 cycle after the pulse edge. The first decrement is visible CLK_HZ cycles after that edge.
- A setpoint of N seconds gives N·CLK_HZ heater_en-high cycles with no pauses.
- The done pulse appears in the same cycle heater_en falls.
- Pause/resume is cycle-exact: the total RUN cycles from start to DONE equal N·CLK_HZ regardless of pauses.
- digit changes every SCAN_DIV cycles. The first change is SCAN_DIV cycles after reset release.
- Reset mid-operation: all registers return to reset values asynchronously. heater_en drops immediately when reset_n goes low.

## Test plan
Parameters: CLK_HZ=4, SCAN_DIV=2.

- Reset then idle: after reset, tLED=000, heater_en=0, done=0. Across 16 cycles digit steps 0,1,2,3,0 every 2 cycles.
- Basic countdown: load set_bcd=0x003, start.
  - heater_en is high for exactly 12 cycles.
  - tLED steps 003→002→001→000 at 4-cycle intervals.
  - done pulses 1 cycle at 000.
  - A further start returns to IDLE with tLED=003.
- BCD borrow: load 0x100, start. After 4 cycles tLED=099. After 40 more cycles tLED=089.
- Pause/resume: load 0x002, start, pause after 6 RUN cycles for 10 cycles, resume.
  - tLED holds at 001 during the pause.
  - Total heater_en-high cycles = 8.
  - done pulses once.
- Clamp and ignore:
  - load 0xABC in IDLE gives tLED=999.
  - load 0x005 while in RUN leaves tLED unchanged.
  - start with tLED=000 in IDLE stays in IDLE.
- Priority and abort:
  - cancel and start in the same cycle during RUN at tLED=005 (setpoint 009) gives IDLE, tLED=009, heater_en=0, no done.
  - reset_n low mid-RUN forces heater_en=0 before the next clock edge.
